// File: rtl/ssd_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller.
// Frame-coherent shadow of the display contents, dead-time guarded digit select, registered active-low outputs.
module ssd_scan_ctrl #(
    parameter int SCAN_DIV = 100000,
    parameter int DEAD     = 2,
    parameter int CNT_W    = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic [3:0]  digit_en,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  ssd_ctrl,
    output logic [7:0]  ssd_out,
    output logic [1:0]  scan_idx,
    output logic        frame_tick
);

    logic [CNT_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] dead_q, dead_d;
    logic [1:0]       scan_d;
    logic [15:0]      sh_digits_q, sh_digits_d;
    logic [3:0]       sh_en_q, sh_en_d;
    logic [3:0]       sh_dp_q, sh_dp_d;
    logic             sh_lz_q, sh_lz_d;
    logic             tick, load, lit, blank;
    logic [3:0]       cur_val;
    logic [6:0]       seg;
    logic [3:0]       ctrl_d;
    logic [7:0]       out_d;

    always_comb begin
        tick    = (presc_q == CNT_W'(SCAN_DIV - 1));
        load    = tick && (scan_idx == 2'd3);
        presc_d = tick ? '0 : presc_q + CNT_W'(1);
        scan_d  = tick ? scan_idx + 2'd1 : scan_idx;
        if (tick)
            dead_d = CNT_W'(DEAD);
        else if (dead_q != '0)
            dead_d = dead_q - CNT_W'(1);
        else
            dead_d = '0;

        sh_digits_d = load ? digits   : sh_digits_q;
        sh_en_d     = load ? digit_en : sh_en_q;
        sh_dp_d     = load ? dp_in    : sh_dp_q;
        sh_lz_d     = load ? blank_lz : sh_lz_q;
    end

    // Outputs are decoded from next-state values so they line up with scan_idx without a cycle of lag.
    always_comb begin
        cur_val = sh_digits_d[{scan_d, 2'b00} +: 4];
        case (scan_d)
            2'd3:    blank = sh_lz_d && (sh_digits_d[15:12] == 4'h0);
            2'd2:    blank = sh_lz_d && (sh_digits_d[15:8] == 8'h00);
            2'd1:    blank = sh_lz_d && (sh_digits_d[15:4] == 12'h000);
            default: blank = 1'b0;
        endcase

        case (cur_val)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase

        lit    = (dead_d == '0) && sh_en_d[scan_d];
        ctrl_d = 4'hF;
        out_d  = 8'hFF;
        if (lit) begin
            ctrl_d = ~(4'b0001 << scan_d);
            out_d  = {(blank ? 7'h7F : seg), ~sh_dp_d[scan_d]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q     <= '0;
            dead_q      <= '0;
            scan_idx    <= 2'd0;
            frame_tick  <= 1'b0;
            sh_digits_q <= '0;
            sh_en_q     <= '0;
            sh_dp_q     <= '0;
            sh_lz_q     <= 1'b0;
            ssd_ctrl    <= 4'hF;
            ssd_out     <= 8'hFF;
        end else begin
            presc_q     <= presc_d;
            dead_q      <= dead_d;
            scan_idx    <= scan_d;
            frame_tick  <= load;
            sh_digits_q <= sh_digits_d;
            sh_en_q     <= sh_en_d;
            sh_dp_q     <= sh_dp_d;
            sh_lz_q     <= sh_lz_d;
            ssd_ctrl    <= ctrl_d;
            ssd_out     <= out_d;
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with SCAN_DIV=8, DEAD=2.
// Expected per-cycle outputs are queued when a frame's inputs are set up and popped as the DUT scans.
module tb_ssd_scan_ctrl;

    localparam int SD = 8;
    localparam int DT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  digit_en;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  ssd_ctrl;
    logic [7:0]  ssd_out;
    logic [1:0]  scan_idx;
    logic        frame_tick;

    typedef struct packed {
        logic [3:0] ctrl;
        logic [7:0] out;
        logic [1:0] idx;
        logic       tick;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;

    ssd_scan_ctrl #(.SCAN_DIV(SD), .DEAD(DT), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .digit_en   (digit_en),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .ssd_ctrl   (ssd_ctrl),
        .ssd_out    (ssd_out),
        .scan_idx   (scan_idx),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    // Expected outputs at position i (0..31) of a frame whose shadow holds d/en/dp/lz.
    function automatic exp_t model(input int i, input logic [15:0] d, input logic [3:0] en,
                                   input logic [3:0] dp, input logic lz);
        exp_t e;
        int s;
        int c;
        logic bl;
        s = i / SD;
        c = i % SD;
        e.idx  = 2'(s);
        e.tick = (i == 0);
        bl = lz && ((s == 3 && d[15:12] == 4'h0) ||
                    (s == 2 && d[15:8] == 8'h00) ||
                    (s == 1 && d[15:4] == 12'h000));
        if (c < DT || !en[s]) begin
            e.ctrl = 4'b1111;
            e.out  = 8'hFF;
        end else begin
            case (s)
                0:       e.ctrl = 4'b1110;
                1:       e.ctrl = 4'b1101;
                2:       e.ctrl = 4'b1011;
                default: e.ctrl = 4'b0111;
            endcase
            e.out = {(bl ? 7'b1111111 : seg7(d[4*s +: 4])), ~dp[s]};
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    endtask

    task automatic push_frame(input logic [15:0] d, input logic [3:0] en,
                              input logic [3:0] dp, input logic lz);
        for (int i = 0; i < 4 * SD; i++) sb.push_back(model(i, d, en, dp, lz));
    endtask

    task automatic push_dark(input int n);
        exp_t e;
        for (int k = 1; k <= n; k++) begin
            e.ctrl = 4'hF;
            e.out  = 8'hFF;
            e.idx  = 2'(k / SD);
            e.tick = 1'b0;
            sb.push_back(e);
        end
    endtask

    task automatic check_cycles(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cyc++;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("ssd_ctrl",   32'(ssd_ctrl),   32'(e.ctrl));
                check("ssd_out",    32'(ssd_out),    32'(e.out));
                check("scan_idx",   32'(scan_idx),   32'(e.idx));
                check("frame_tick", 32'(frame_tick), 32'(e.tick));
            end
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_ctrl_async", 32'(ssd_ctrl),   32'h F);
        check("rst_out_async",  32'(ssd_out),    32'h FF);
        check("rst_idx_async",  32'(scan_idx),   32'h0);
        check("rst_tick_async", 32'(frame_tick), 32'h0);
        @(negedge clk);
        check("rst_ctrl_held",  32'(ssd_ctrl),   32'h F);
        check("rst_out_held",   32'(ssd_out),    32'h FF);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        rst      = 1'b1;
        digits   = 16'h1208;
        digit_en = 4'b1111;
        dp_in    = 4'b0000;
        blank_lz = 1'b0;
        do_reset();
        push_dark(31);
        check_cycles(31);

        // Frame A: 1208, inputs changed mid-frame must stay invisible
        push_frame(16'h1208, 4'b1111, 4'b0000, 1'b0);
        check_cycles(16);
        digits = 16'h0050; dp_in = 4'b0001; blank_lz = 1'b1;
        check_cycles(16);

        // Frame B: leading-zero blanking with a decimal point
        push_frame(16'h0050, 4'b1111, 4'b0001, 1'b1);
        check_cycles(16);
        digits = 16'h1111; dp_in = 4'b0000; blank_lz = 1'b0;
        check_cycles(16);

        // Frame C: change to 2222 during slot 1
        push_frame(16'h1111, 4'b1111, 4'b0000, 1'b0);
        check_cycles(10);
        digits = 16'h2222; digit_en = 4'b0101;
        check_cycles(22);

        // Frame D: disabled digits keep their slots
        push_frame(16'h2222, 4'b0101, 4'b0000, 1'b0);
        check_cycles(16);
        digits = 16'h0009; digit_en = 4'b1111; blank_lz = 1'b1;
        check_cycles(16);

        // Frame E: interrupted by reset in slot 2
        push_frame(16'h0009, 4'b1111, 4'b0000, 1'b1);
        check_cycles(19);
        digits = 16'hFEDC; dp_in = 4'b1010;
        sb.delete();
        do_reset();
        push_dark(31);
        check_cycles(31);

        push_frame(16'hFEDC, 4'b1111, 4'b1010, 1'b1);
        check_cycles(16);
        digits = 16'h7654; digit_en = 4'b1011; dp_in = 4'b0100; blank_lz = 1'b0;
        check_cycles(16);

        push_frame(16'h7654, 4'b1011, 4'b0100, 1'b0);
        check_cycles(32);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
